// File: rtl/munoc_req_flit_packetizer.sv
// -----------------------------------------------------------------------------
// munoc_req_flit_packetizer
//
// Request-side injection stage of the MUNOC network interface. Accepts one
// request (address, burst length, write flag) and, for writes, its data
// beats. It turns these into a head/body/tail flit stream for the router
// input port. The captured address is driven to the external address
// decoder, and the decoder's target node is packed into the header flit.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_*         request handshake: addr / write / len (beats-1)
//   wdata_*       write-beat handshake; wdata_last is only cross-checked
//   dec_addr      registered address to the decoder
//   dec_target    combinational target node returned by the decoder
//   flit_*        flit handshake to the router: type and payload
//   err_last      sticky flag: wdata_last disagreed with the beat count
//
// Flit types: 00 head, 01 body, 10 tail, 11 head+tail (read request).
// Header layout (LSB first): addr, len, write, SRC_NODE, dec_target, zero pad.
// -----------------------------------------------------------------------------
module munoc_req_flit_packetizer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NODE_WIDTH = 4,
    parameter int                    LEN_WIDTH  = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FLIT_WIDTH = 64,
    parameter logic [NODE_WIDTH-1:0] SRC_NODE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_last,
    output logic [ADDR_WIDTH-1:0] dec_addr,
    input  logic [NODE_WIDTH-1:0] dec_target,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic [1:0]            flit_type,
    output logic [FLIT_WIDTH-1:0] flit_data,
    output logic                  err_last
);

    localparam int HDR_W = ADDR_WIDTH + LEN_WIDTH + 1 + 2 * NODE_WIDTH;

    localparam logic [1:0] FT_HEAD      = 2'b00;
    localparam logic [1:0] FT_BODY      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_e;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   write_q;
    logic [LEN_WIDTH-1:0]   beat_cnt_q;
    logic                   err_last_q;

    logic [HDR_W-1:0]       header;
    logic                   last_beat;

    // The decoder sees only the registered address, so the header path is
    // addr_q -> decoder -> flit_data with no combinational path from req_*.
    assign dec_addr  = addr_q;
    assign header    = {dec_target, SRC_NODE, write_q, len_q, addr_q};
    assign last_beat = (beat_cnt_q == '0);
    assign err_last  = err_last_q;

    // Handshake outputs are decoded from the state. In BODY the flit is a
    // pass-through of the write beat, so the data source must hold wdata
    // stable while the router stalls.
    always_comb begin
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        flit_valid  = 1'b0;
        flit_type   = FT_HEAD;
        flit_data   = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = ~rst;
            end
            ST_HEAD: begin
                flit_valid = 1'b1;
                flit_type  = write_q ? FT_HEAD : FT_HEAD_TAIL;
                flit_data  = FLIT_WIDTH'(header);
            end
            ST_BODY: begin
                flit_valid  = wdata_valid;
                wdata_ready = flit_ready;
                flit_type   = last_beat ? FT_TAIL : FT_BODY;
                flit_data   = FLIT_WIDTH'(wdata);
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A packet in flight is abandoned; the router deals with the
            // truncated packet.
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            write_q    <= 1'b0;
            beat_cnt_q <= '0;
            err_last_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        len_q   <= req_len;
                        write_q <= req_write;
                        state_q <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (flit_ready) begin
                        if (write_q) begin
                            beat_cnt_q <= len_q;
                            state_q    <= ST_BODY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_BODY: begin
                    if (wdata_valid && flit_ready) begin
                        // The beat count ends the packet; wdata_last is only
                        // compared against it.
                        if (wdata_last != last_beat) begin
                            err_last_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
